threewire_slave: RTL

- Slave/responder end of the team's 3-wire serial bus: clock, active-low chip select, one bidirectional data line.
- Runs on a local system clock. Oversamples the bus, decodes R/W + address + data frames, and presents them as a register-access handshake to local logic.
- Drives read data back onto the shared data line during read frames.
- Used on the far side of the bus from the 3-wire master, e.g. to expose a register file in a second FPGA or a test harness.

---
 rtl/threewire_slave.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/threewire_slave.sv
// threewire_slave: responder end of the 3-wire serial bus (clock, active-low
// chip select, bidirectional data). Oversamples the bus on the local clock,
// decodes R/W + address + data frames and turns them into a register-access
// handshake. Drives read data back on the shared line during read frames.
//
// Ports:
//   in_clk, in_rst_n   local clock (>= 8x bus clock), async active-low reset
//   in_tw_clock        bus clock from master
//   in_tw_cs           bus chip select, active-low
//   io_tw_data         bus data; driven only during the read data phase
//   out_addr           decoded address, valid from rd_req/wr_strobe to next frame
//   out_wr_data        decoded write data, valid with out_wr_strobe
//   out_wr_strobe      1-cycle pulse, write frame completed
//   out_rd_req         1-cycle pulse, read frame address decoded
//   in_rd_data         read data from local logic
//   out_busy           high while a frame is in progress
//   out_frame_err      1-cycle pulse, CS deasserted mid-frame
//
// Optional feature: define THREEWIRE_SLAVE_ADDR_MATCH_EN to ignore frames whose
// address does not match ADDR_BASE under ADDR_MASK.

module threewire_slave #(
  parameter int unsigned          ADDR_BITS = 9,
  parameter int unsigned          DATA_BITS = 16,
  parameter logic [ADDR_BITS-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_BITS-1:0] ADDR_MASK = {ADDR_BITS{1'b1}}
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic                 in_tw_clock,
  input  logic                 in_tw_cs,
  inout  wire                  io_tw_data,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [DATA_BITS-1:0] out_wr_data,
  output logic                 out_wr_strobe,
  output logic                 out_rd_req,
  input  logic [DATA_BITS-1:0] in_rd_data,
  output logic                 out_busy,
  output logic                 out_frame_err
);

  localparam int unsigned CNT_MAX = (ADDR_BITS > DATA_BITS) ? ADDR_BITS : DATA_BITS;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RW,
    S_ADDR,
    S_TURN,
    S_WDATA,
    S_RDRIVE,
    S_DONE
  } state_t;

  // Synchronizers and edge-detect history
  logic [1:0] clk_sync, cs_sync, dat_sync;
  logic       clk_prev, cs_prev;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      clk_sync <= 2'b00;
      cs_sync  <= 2'b11;
      dat_sync <= 2'b00;
      clk_prev <= 1'b0;
      cs_prev  <= 1'b1;
    end else begin
      clk_sync <= {clk_sync[0], in_tw_clock};
      cs_sync  <= {cs_sync[0], in_tw_cs};
      dat_sync <= {dat_sync[0], io_tw_data};
      clk_prev <= clk_sync[1];
      cs_prev  <= cs_sync[1];
    end
  end

  logic clk_s, cs_s, dat_s, tw_rise, tw_fall, cs_fall;
  assign clk_s   = clk_sync[1];
  assign cs_s    = cs_sync[1];
  assign dat_s   = dat_sync[1];
  assign tw_rise = clk_s & ~clk_prev;
  assign tw_fall = ~clk_s & clk_prev;
  assign cs_fall = ~cs_s & cs_prev;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 turn_q, turn_d;
  logic                 drive_q, drive_d;
  logic                 is_write_q, is_write_d;
  logic [ADDR_BITS-1:0] addr_d, addr_shifted;
  logic [DATA_BITS-1:0] wr_data_d;
  logic                 wr_strobe_d, rd_req_d, frame_err_d, busy_d;
  logic                 addr_hit;

  assign addr_shifted = {out_addr[ADDR_BITS-2:0], dat_s};

`ifdef THREEWIRE_SLAVE_ADDR_MATCH_EN
  assign addr_hit = ((addr_shifted & ADDR_MASK) == (ADDR_BASE & ADDR_MASK));
`else
  logic unused_cfg;
  assign unused_cfg = ^{ADDR_BASE, ADDR_MASK};
  assign addr_hit   = 1'b1;
`endif

  // Line is released in the same cycle the synced CS rise is seen
  assign io_tw_data = (drive_q && !cs_s) ? shift_q[DATA_BITS-1] : 1'bz;

  // Frame decoder next-state and outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    turn_d      = turn_q;
    drive_d     = drive_q;
    is_write_d  = is_write_q;
    addr_d      = out_addr;
    wr_data_d   = out_wr_data;
    wr_strobe_d = 1'b0;
    rd_req_d    = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs_fall) state_d = S_RW;
      end
      S_RW: begin
        if (tw_rise) begin
          is_write_d = dat_s;
          cnt_d      = CNT_W'(ADDR_BITS - 1);
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (tw_rise) begin
          addr_d = addr_shifted;
          if (cnt_q == '0) begin
            if (!addr_hit) begin
              state_d = S_DONE;
            end else if (is_write_q) begin
              cnt_d   = CNT_W'(DATA_BITS - 1);
              state_d = S_WDATA;
            end else begin
              rd_req_d = 1'b1;
              turn_d   = 1'b0;
              state_d  = S_TURN;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_TURN: begin
        // First fall closes the last address bit, second closes turnaround
        if (tw_fall) begin
          if (!turn_q) begin
            turn_d = 1'b1;
          end else begin
            shift_d = in_rd_data;
            drive_d = 1'b1;
            cnt_d   = CNT_W'(DATA_BITS - 1);
            state_d = S_RDRIVE;
          end
        end
      end
      S_WDATA: begin
        if (tw_rise) begin
          shift_d = {shift_q[DATA_BITS-2:0], dat_s};
          if (cnt_q == '0) begin
            wr_data_d   = {shift_q[DATA_BITS-2:0], dat_s};
            wr_strobe_d = 1'b1;
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      S_RDRIVE: begin
        // Master samples on each fall; move to the next bit right after
        if (tw_fall) begin
          if (cnt_q != '0) begin
            cnt_d   = cnt_q - CNT_W'(1);
            shift_d = {shift_q[DATA_BITS-2:0], 1'b0};
          end else begin
            drive_d = 1'b0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (cs_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Aborted frame: CS released before the frame finished
    if (cs_s && (state_q inside {S_RW, S_ADDR, S_TURN, S_WDATA, S_RDRIVE})) begin
      state_d     = S_IDLE;
      drive_d     = 1'b0;
      frame_err_d = 1'b1;
      wr_strobe_d = 1'b0;
      rd_req_d    = 1'b0;
      wr_data_d   = out_wr_data;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      shift_q       <= '0;
      turn_q        <= 1'b0;
      drive_q       <= 1'b0;
      is_write_q    <= 1'b0;
      out_addr      <= '0;
      out_wr_data   <= '0;
      out_wr_strobe <= 1'b0;
      out_rd_req    <= 1'b0;
      out_busy      <= 1'b0;
      out_frame_err <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      turn_q        <= turn_d;
      drive_q       <= drive_d;
      is_write_q    <= is_write_d;
      out_addr      <= addr_d;
      out_wr_data   <= wr_data_d;
      out_wr_strobe <= wr_strobe_d;
      out_rd_req    <= rd_req_d;
      out_busy      <= busy_d;
      out_frame_err <= frame_err_d;
    end
  end

endmodule
